// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
//
// Hazard and stall controller for a classic five-stage in-order pipeline
// (IF, ID, EX, MEM, WB). It produces the per-stage register enables and
// bubble-insert flushes, tracks outstanding data-memory accesses, declares a
// sticky fault if memory never answers, and counts fetch-stall cycles.
//
// Parameters
//   MEM_TIMEOUT : maximum MEM_WAIT cycles before a fault is declared
//   CNT_W       : width of the stall counter
//
// Ports
//   clk, rst                 : clock, asynchronous active-high reset
//   id_rs1, id_rs2           : source register indices of the ID instruction
//   id_rs1_used, id_rs2_used : the corresponding source is actually read
//   ex_rd                    : destination register index of the EX instruction
//   ex_is_load, ex_rd_wren   : EX instruction is a load / writes rd
//   branch_taken             : EX redirects the PC this cycle
//   imem_stall               : fetched instruction not yet valid
//   mem_req, mem_ack         : MEM stage access request / completion
//   stall_cnt_clr            : synchronous clear of stall_cnt
//   pc_en .. mem_wb_en       : pipeline register enables
//   if_id_flush .. mem_wb_flush : load a bubble into that pipeline register
//   mem_busy                 : controller is waiting on data memory
//   timeout_err              : sticky memory-timeout fault flag
//   stall_cnt                : saturating count of cycles with pc_en low
// ---------------------------------------------------------------------------
module pipeline_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_rd_wren,
  input  logic             branch_taken,
  input  logic             imem_stall,
  input  logic             mem_req,
  input  logic             mem_ack,
  input  logic             stall_cnt_clr,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic             mem_busy,
  output logic             timeout_err,
  output logic [CNT_W-1:0] stall_cnt
);

  // wait_cnt only has to hold 0 .. MEM_TIMEOUT-1: the last value triggers the fault.
  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_next_s;
  logic [WAIT_W-1:0]  wait_cnt_r;
  logic [WAIT_W-1:0]  wait_cnt_next_s;
  logic               timeout_err_r;
  logic [CNT_W-1:0]   stall_cnt_r;

  logic               load_use_s;
  logic               pc_en_s;
  logic               if_id_en_s;
  logic               id_ex_en_s;
  logic               ex_mem_en_s;
  logic               mem_wb_en_s;
  logic               if_id_flush_s;
  logic               id_ex_flush_s;
  logic               mem_wb_flush_s;
  logic               count_stall_s;

  // Load-use hazard: ID reads a register that the load in EX has not produced yet.
  always_comb begin
    load_use_s = 1'b0;
    if (ex_is_load && ex_rd_wren && (ex_rd != 5'd0)) begin
      load_use_s = (id_rs1_used && (id_rs1 == ex_rd)) ||
                   (id_rs2_used && (id_rs2 == ex_rd));
    end else begin
      load_use_s = 1'b0;
    end
  end

  // Next-state and enable/flush decode. An un-acked memory access outranks
  // the ID/IF hazards because every older stage must freeze behind it; the
  // stalled MEM instruction is replaced by a bubble heading into WB.
  always_comb begin
    state_next_s    = state_r;
    wait_cnt_next_s = wait_cnt_r;
    pc_en_s         = 1'b1;
    if_id_en_s      = 1'b1;
    id_ex_en_s      = 1'b1;
    ex_mem_en_s     = 1'b1;
    mem_wb_en_s     = 1'b1;
    if_id_flush_s   = 1'b0;
    id_ex_flush_s   = 1'b0;
    mem_wb_flush_s  = 1'b0;

    case (state_r)
      ST_RUN: begin
        wait_cnt_next_s = {WAIT_W{1'b0}};
        if (mem_req && !mem_ack) begin
          pc_en_s        = 1'b0;
          if_id_en_s     = 1'b0;
          id_ex_en_s     = 1'b0;
          ex_mem_en_s    = 1'b0;
          mem_wb_flush_s = 1'b1;
          state_next_s   = ST_MEM_WAIT;
        end else if (branch_taken) begin
          // Redirect wins over imem_stall: the pending fetch is discarded anyway.
          if_id_flush_s = 1'b1;
          id_ex_flush_s = 1'b1;
        end else if (load_use_s) begin
          // Hold PC and IF/ID, let EX drain with a bubble behind it.
          pc_en_s       = 1'b0;
          if_id_en_s    = 1'b0;
          id_ex_flush_s = 1'b1;
        end else if (imem_stall) begin
          pc_en_s       = 1'b0;
          if_id_flush_s = 1'b1;
        end else begin
          pc_en_s = 1'b1;
        end
      end

      ST_MEM_WAIT: begin
        if (mem_ack) begin
          wait_cnt_next_s = {WAIT_W{1'b0}};
          state_next_s    = ST_RUN;
        end else begin
          pc_en_s        = 1'b0;
          if_id_en_s     = 1'b0;
          id_ex_en_s     = 1'b0;
          ex_mem_en_s    = 1'b0;
          mem_wb_flush_s = 1'b1;
          if (wait_cnt_r == WAIT_LAST) begin
            wait_cnt_next_s = {WAIT_W{1'b0}};
            state_next_s    = ST_ERROR;
          end else begin
            wait_cnt_next_s = wait_cnt_r + WAIT_W'(1);
          end
        end
      end

      ST_ERROR: begin
        pc_en_s     = 1'b0;
        if_id_en_s  = 1'b0;
        id_ex_en_s  = 1'b0;
        ex_mem_en_s = 1'b0;
        mem_wb_en_s = 1'b0;
      end

      default: begin
        pc_en_s      = 1'b0;
        if_id_en_s   = 1'b0;
        id_ex_en_s   = 1'b0;
        ex_mem_en_s  = 1'b0;
        mem_wb_en_s  = 1'b0;
        state_next_s = ST_ERROR;
      end
    endcase
  end

  // ERROR is a parking state: its pc_en=0 is not a pipeline stall.
  always_comb begin
    count_stall_s = 1'b0;
    if ((state_r == ST_RUN) || (state_r == ST_MEM_WAIT)) begin
      count_stall_s = !pc_en_s;
    end else begin
      count_stall_s = 1'b0;
    end
  end

  // FSM state, wait counter and sticky fault flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_RUN;
      wait_cnt_r    <= {WAIT_W{1'b0}};
      timeout_err_r <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      wait_cnt_r    <= wait_cnt_next_s;
      timeout_err_r <= timeout_err_r || (state_next_s == ST_ERROR);
    end
  end

  // Saturating stall counter; clear outranks increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (stall_cnt_clr) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (count_stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + CNT_W'(1);
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  // Enables and flushes are combinational so hazards act in the same cycle;
  // reset forces every control low immediately.
  assign pc_en        = pc_en_s        & ~rst;
  assign if_id_en     = if_id_en_s     & ~rst;
  assign id_ex_en     = id_ex_en_s     & ~rst;
  assign ex_mem_en    = ex_mem_en_s    & ~rst;
  assign mem_wb_en    = mem_wb_en_s    & ~rst;
  assign if_id_flush  = if_id_flush_s  & ~rst;
  assign id_ex_flush  = id_ex_flush_s  & ~rst;
  assign ex_mem_flush = 1'b0;
  assign mem_wb_flush = mem_wb_flush_s & ~rst;
  assign mem_busy     = (state_r == ST_MEM_WAIT) & ~rst;
  assign timeout_err  = timeout_err_r;
  assign stall_cnt    = stall_cnt_r;

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

  localparam int TMO = 4;
  localparam int CW  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic [4:0]    id_rs1 = 5'd0, id_rs2 = 5'd0, ex_rd = 5'd0;
  logic          id_rs1_used = 1'b0, id_rs2_used = 1'b0;
  logic          ex_is_load = 1'b0, ex_rd_wren = 1'b0;
  logic          branch_taken = 1'b0, imem_stall = 1'b0;
  logic          mem_req = 1'b0, mem_ack = 1'b0, stall_cnt_clr = 1'b0;
  logic          pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic          if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic          mem_busy, timeout_err;
  logic [CW-1:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  pipeline_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_rd_wren(ex_rd_wren),
    .branch_taken(branch_taken), .imem_stall(imem_stall),
    .mem_req(mem_req), .mem_ack(mem_ack), .stall_cnt_clr(stall_cnt_clr),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
    .mem_busy(mem_busy), .timeout_err(timeout_err), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: "waiting on memory", number of wait cycles spent,
  // "faulted", and an integer stall count.
  bit m_wait  = 1'b0;
  bit m_fault = 1'b0;
  int m_waits = 0;
  int m_cnt   = 0;

  // {pc,if_id,id_ex,ex_mem,mem_wb enables, if_id,id_ex,ex_mem,mem_wb flushes, busy}
  function automatic logic [9:0] model_ctrl();
    logic lu;
    lu = ex_is_load && ex_rd_wren && (ex_rd != 5'd0) &&
         ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
    if (rst)                  return 10'b00000_0000_0;
    if (m_fault)              return 10'b00000_0000_0;
    if (m_wait)               return mem_ack ? 10'b11111_0000_1 : 10'b00001_0001_1;
    if (mem_req && !mem_ack)  return 10'b00001_0001_0;
    if (branch_taken)         return 10'b11111_1100_0;
    if (lu)                   return 10'b00111_0100_0;
    if (imem_stall)           return 10'b01111_1000_0;
    return 10'b11111_0000_0;
  endfunction

  // Compare process: every negedge, DUT outputs against the model.
  always @(negedge clk) begin
    if (rst) begin
      m_wait = 1'b0; m_fault = 1'b0; m_waits = 0; m_cnt = 0;
    end
    chk("ctrl_vec",
        {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
         if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, mem_busy},
        model_ctrl());
    chk("timeout_err", timeout_err, m_fault);
    chk("stall_cnt", stall_cnt, m_cnt);
  end

  // Model update on each rising edge using the inputs of the ending cycle.
  always @(posedge clk) begin
    logic [9:0] c;
    if (rst) begin
      m_wait = 1'b0; m_fault = 1'b0; m_waits = 0; m_cnt = 0;
    end else begin
      c = model_ctrl();
      if (stall_cnt_clr)                m_cnt = 0;
      else if (!m_fault && !c[9])       m_cnt = (m_cnt + 1 > (1 << CW) - 1) ? (1 << CW) - 1 : m_cnt + 1;
      if (m_wait) begin
        if (mem_ack) begin
          m_wait = 1'b0; m_waits = 0;
        end else begin
          m_waits++;
          if (m_waits == TMO) begin
            m_fault = 1'b1; m_wait = 1'b0;
          end
        end
      end else if (!m_fault && mem_req && !mem_ack) begin
        m_wait = 1'b1; m_waits = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    ex_is_load = 1'b0; ex_rd_wren = 1'b0;
    branch_taken = 1'b0; imem_stall = 1'b0;
    mem_req = 1'b0; mem_ack = 1'b0; stall_cnt_clr = 1'b0;
  endtask

  initial begin
    set_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_pc_en", pc_en, 32'd0);
    chk("rst_mem_wb_en", mem_wb_en, 32'd0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    chk("rst_terr", timeout_err, 32'd0);
    rst = 1'b0;
    #1;
    chk("idle_pc_en", pc_en, 32'd1);
    tick();

    // Load-use on rs2
    ex_is_load = 1'b1; ex_rd = 5'd5; ex_rd_wren = 1'b1; id_rs2 = 5'd5; id_rs2_used = 1'b1;
    #1;
    chk("lu_pc_en", pc_en, 32'd0);
    chk("lu_if_id_en", if_id_en, 32'd0);
    chk("lu_id_ex_en", id_ex_en, 32'd1);
    chk("lu_id_ex_flush", id_ex_flush, 32'd1);
    tick();

    // Same with ex_rd = 0: no hazard
    ex_rd = 5'd0; id_rs2 = 5'd0;
    #1;
    chk("lu_cnt", stall_cnt, 32'd1);
    chk("rd0_pc_en", pc_en, 32'd1);
    chk("rd0_id_ex_flush", id_ex_flush, 32'd0);
    tick();

    // Branch beats load-use and imem_stall
    ex_rd = 5'd5; id_rs2 = 5'd5; branch_taken = 1'b1; imem_stall = 1'b1;
    #1;
    chk("br_pc_en", pc_en, 32'd1);
    chk("br_if_id_flush", if_id_flush, 32'd1);
    chk("br_id_ex_flush", id_ex_flush, 32'd1);
    tick();

    // imem_stall alone
    set_idle(); imem_stall = 1'b1;
    #1;
    chk("im_pc_en", pc_en, 32'd0);
    chk("im_if_id_en", if_id_en, 32'd1);
    chk("im_if_id_flush", if_id_flush, 32'd1);
    tick();

    // Memory wait: ack low for 3 cycles, then ack
    set_idle(); mem_req = 1'b1;
    #1;
    chk("mw0_busy", mem_busy, 32'd0);
    chk("mw0_wb_flush", mem_wb_flush, 32'd1);
    chk("mw0_cnt", stall_cnt, 32'd2);
    tick(); #1;
    chk("mw1_busy", mem_busy, 32'd1);
    tick(); #1;
    chk("mw2_busy", mem_busy, 32'd1);
    chk("mw2_wb_en", mem_wb_en, 32'd1);
    tick();
    mem_ack = 1'b1;
    #1;
    chk("mwack_busy", mem_busy, 32'd1);
    chk("mwack_pc_en", pc_en, 32'd1);
    chk("mwack_wb_flush", mem_wb_flush, 32'd0);
    tick();
    set_idle();
    #1;
    chk("mwdone_busy", mem_busy, 32'd0);
    chk("mwdone_cnt", stall_cnt, 32'd5);

    // Saturation, then clear against a concurrent stall
    imem_stall = 1'b1;
    repeat (20) tick();
    #1;
    chk("sat_cnt", stall_cnt, 32'd15);
    stall_cnt_clr = 1'b1;
    tick(); #1;
    chk("clr_cnt", stall_cnt, 32'd0);
    set_idle();
    tick();

    // Timeout: ack never returns
    mem_req = 1'b1;
    tick();
    repeat (3) tick();
    #1;
    chk("to_wait4_terr", timeout_err, 32'd0);
    chk("to_wait4_busy", mem_busy, 32'd1);
    tick(); #1;
    chk("to_terr", timeout_err, 32'd1);
    chk("to_pc_en", pc_en, 32'd0);
    chk("to_wb_en", mem_wb_en, 32'd0);
    chk("to_busy", mem_busy, 32'd0);
    mem_ack = 1'b1;
    tick(); #1;
    chk("to_hold_terr", timeout_err, 32'd1);
    chk("to_hold_pc_en", pc_en, 32'd0);
    chk("to_hold_cnt", stall_cnt, 32'd5);

    // Reset leaves ERROR
    rst = 1'b1;
    #1;
    chk("rst_err_terr", timeout_err, 32'd0);
    tick();
    rst = 1'b0; set_idle();
    #1;
    chk("post_err_pc_en", pc_en, 32'd1);
    tick();

    // Reset mid-MEM_WAIT
    mem_req = 1'b1;
    tick(); #1;
    chk("mid_busy", mem_busy, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", mem_busy, 32'd0);
    chk("mid_rst_pc_en", pc_en, 32'd0);
    tick();
    rst = 1'b0; mem_req = 1'b0;
    #1;
    chk("mid_post_busy", mem_busy, 32'd0);
    chk("mid_post_pc_en", pc_en, 32'd1);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
